// File: rtl/vga_timing_1280x1024_if.sv
// vga_timing_1280x1024_if: raster coordinates plus delayed DAC sync/blank bundle
interface vga_timing_1280x1024_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        disp_en;
  logic        frame_start;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  modport master(output x, y, disp_en, frame_start, VGA_HS, VGA_VS, VGA_BLANK_N);
  modport slave(input x, y, disp_en, frame_start, VGA_HS, VGA_VS, VGA_BLANK_N);
endinterface

// File: rtl/vga_timing_1280x1024.sv
// vga_timing_1280x1024: free-running raster counters with registered decode and delayed DAC syncs
module vga_timing_1280x1024 #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 48,
  parameter int H_SYNC     = 112,
  parameter int H_BP       = 248,
  parameter int V_ACTIVE   = 1024,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 38,
  parameter bit H_POL      = 1'b1,
  parameter bit V_POL      = 1'b1,
  parameter int SYNC_DELAY = 1
) (
  input logic                    VGA_CLK,
  input logic                    reset_n,
  vga_timing_1280x1024_if.master vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, y_q;
  logic disp_en_q, frame_start_q, hs_q, vs_q, h_last, v_last;
  logic [SYNC_DELAY-1:0] hs_dly_q, vs_dly_q, blank_dly_q;
  always_comb begin
    h_last  = h_cnt_q == 11'(H_TOTAL - 1);
    v_last  = v_cnt_q == 11'(V_TOTAL - 1);
    h_cnt_d = h_last ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = !h_last ? v_cnt_q : v_last ? 11'd0 : v_cnt_q + 11'd1;
  end
  always_ff @(posedge VGA_CLK or negedge reset_n)
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      disp_en_q     <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hs_dly_q      <= '0;
      vs_dly_q      <= '0;
      blank_dly_q   <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
      disp_en_q     <= h_cnt_q < 11'(H_ACTIVE) && v_cnt_q < 11'(V_ACTIVE);
      frame_start_q <= h_cnt_q == 11'd0 && v_cnt_q == 11'd0;
      hs_q          <= h_cnt_q >= 11'(HS_START) && h_cnt_q < 11'(HS_END);
      vs_q          <= v_cnt_q >= 11'(VS_START) && v_cnt_q < 11'(VS_END);
      hs_dly_q      <= SYNC_DELAY'({hs_dly_q, hs_q});
      vs_dly_q      <= SYNC_DELAY'({vs_dly_q, vs_q});
      blank_dly_q   <= SYNC_DELAY'({blank_dly_q, disp_en_q});
    end
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.disp_en     = disp_en_q;
  assign vga.frame_start = frame_start_q;
  assign vga.VGA_HS      = H_POL ? hs_dly_q[SYNC_DELAY-1] : !hs_dly_q[SYNC_DELAY-1];
  assign vga.VGA_VS      = V_POL ? vs_dly_q[SYNC_DELAY-1] : !vs_dly_q[SYNC_DELAY-1];
  assign vga.VGA_BLANK_N = blank_dly_q[SYNC_DELAY-1];
endmodule

// File: doc/vga_timing_1280x1024.md
# vga_timing_1280x1024

Raster timing generator for the 1280x1024@60 Hz display path. Runs on the 108 MHz pixel clock and produces pixel coordinates (`x`, `y`) and the active-area flag (`disp_en`) that drive the downstream pixel-colour stage. It also produces the sync and blank outputs for the DAC. The DAC outputs are delayed so they line up with that stage's one-cycle registered RGB.

## Interface
Parameters:
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch (pixels)
- `H_SYNC`, 112, horizontal sync width (pixels)
- `H_BP`, 248, horizontal back porch; H_TOTAL = 1688
- `V_ACTIVE`, 1024, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vertical sync width (lines)
- `V_BP`, 38, vertical back porch; V_TOTAL = 1066
- `H_POL`, 1, hsync asserted level (1 = active-high)
- `V_POL`, 1, vsync asserted level
- `SYNC_DELAY`, 1, extra cycles (1..4) applied to VGA_HS/VGA_VS/VGA_BLANK_N, matching downstream colour latency

Ports:
- `VGA_CLK`  in  1  pixel clock, 108 MHz, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `x`  out  11  horizontal counter value, registered
- `y`  out  11  vertical counter value, registered
- `disp_en`  out  1  high when (x,y) is inside the active area
- `frame_start`  out  1  one-cycle pulse coincident with x=0,y=0
- `VGA_HS`  out  1  horizontal sync, polarity H_POL, delayed SYNC_DELAY
- `VGA_VS`  out  1  vertical sync, polarity V_POL, delayed SYNC_DELAY
- `VGA_BLANK_N`  out  1  disp_en delayed SYNC_DELAY

## Operation
- Internal counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1), 11 bits each.
- Counter behaviour on each rising edge:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `v_cnt` = V_TOTAL-1 with `h_cnt` = H_TOTAL-1, both wrap to 0.
- Output stage, on each edge (before counters advance), registers a decode of the current counters:
  - `x` ← `h_cnt`, `y` ← `v_cnt`.
  - `disp_en` ← (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
  - `frame_start` ← (`h_cnt` == 0 && `v_cnt` == 0).
  - Internal `hs_i` ← `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [1328,1440).
  - Internal `vs_i` ← `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [1025,1028).
- `x`, `y` are not forced to 0 during blanking; they carry the raw counter values (max 1687/1065, fits in 11 bits).
- Delay line: `hs_i`, `vs_i` and `disp_en` each pass through a SYNC_DELAY-stage shift register.
- Pin polarity: `VGA_HS` = delayed `hs_i` when H_POL=1, else its inverse; `VGA_VS` likewise with V_POL.
- No enable input: the block free-runs continuously out of reset.

## Timing
- Reset values, applied immediately on `reset_n` low, independent of clock:
  - `h_cnt` = `v_cnt` = 0; `x` = `y` = 0.
  - `disp_en` = 0, `frame_start` = 0, `VGA_BLANK_N` = 0.
  - `VGA_HS` = !H_POL, `VGA_VS` = !V_POL; all delay stages cleared to the deasserted level.
- First rising edge after `reset_n` rises: x=0, y=0, disp_en=1, frame_start=1.
- Latency:
  - `x`/`y`/`disp_en`/`frame_start` lag the counters by 1 cycle.
  - `VGA_HS`/`VGA_VS`/`VGA_BLANK_N` lag `x`/`disp_en` by exactly SYNC_DELAY further cycles.
- Line period: 1688 cycles; `disp_en` high for 1280 consecutive cycles per active line, 0 for lines 1024..1065.
- Frame period: 1688 × 1066 = 1,799,408 cycles; `frame_start` high exactly once per frame.
- Wrap points:
  - After x=1687, the next cycle shows x=0, y+1.
  - After (1687,1065), the next cycle shows (0,0) with frame_start=1.
- Mid-frame reset: all outputs return to reset values asynchronously. Restart is always from (0,0); no partial frame is resumed.

## Test plan
- Reset hold 10 cycles, release → x=0, y=0, disp_en=0, VGA_HS=0, VGA_VS=0, VGA_BLANK_N=0 during reset; first edge after release gives x=0, y=0, disp_en=1, frame_start=1.
- Line scan on y=0 → disp_en high for x=0..1279 (1280 cycles) and low for x=1280..1687. `hs_i` high for x=1328..1439 (112 cycles); VGA_HS shows the same window one cycle later at SYNC_DELAY=1.
- Line wrap → x=1687,y=5 followed by x=0,y=6; no cycle with x=1688.
- Full frame → VGA_VS high for 3×1688 = 5064 cycles starting at (0,1025)+SYNC_DELAY. frame_start pulses are 1,799,408 cycles apart; (1687,1065) is followed by (0,0).
- Mid-frame reset at (700,500) → outputs go to reset values without a clock edge; after release, the sequence restarts at (0,0) with frame_start=1.
- SYNC_DELAY=3, H_POL=0 → VGA_BLANK_N equals disp_en delayed 3 cycles; VGA_HS is low for x=1328..1439 delayed 3 cycles and high elsewhere.
